// File: rtl/run_pkg.sv
// Shared state encoding, default run-control constants and state-decode helpers
// used by the sequencer, its sub-module and the bench.
package run_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        CLEAR = 3'd2,
        RUN   = 3'd3,
        DONE  = 3'd4,
        FAULT = 3'd5
    } run_state_t;

    localparam int RUN_PCW          = 7;
    localparam int RUN_CW           = 12;
    localparam int RUN_MAX_CYCLES   = 2000;
    localparam int RUN_CLR_CYCLES   = 2;
    localparam int RUN_STALL_CYCLES = 1;

    function automatic logic holds_core_rst(input run_state_t s);
        return (s == IDLE) || (s == ARM) || (s == CLEAR);
    endfunction

    function automatic logic is_busy(input run_state_t s);
        return (s == ARM) || (s == CLEAR) || (s == RUN);
    endfunction

    function automatic logic is_finished(input run_state_t s);
        return (s == DONE) || (s == FAULT);
    endfunction

endpackage

// File: rtl/pc_stall_detect.sv
// Flags a stalled program counter: pc unchanged for STALL_CYCLES consecutive
// enabled cycles, with the first cycle of a run never compared.
module pc_stall_detect
    import run_pkg::*;
#(
    parameter int PCW          = RUN_PCW,
    parameter int STALL_CYCLES = RUN_STALL_CYCLES
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clr_i,
    input  logic           en_i,
    input  logic           first_i,
    input  logic [PCW-1:0] pc_i,
    output logic           stall_o
);

    localparam int SCW = $clog2(STALL_CYCLES + 1);
    localparam logic [SCW-1:0] STALL_LAST = SCW'(STALL_CYCLES - 1);
    localparam logic [SCW-1:0] STALL_MAX  = SCW'(STALL_CYCLES);

    logic [PCW-1:0] prev_pc_q, prev_pc_d;
    logic [SCW-1:0] stall_cnt_q, stall_cnt_d;
    logic           same_s;

    assign same_s  = (pc_i == prev_pc_q);
    // Stall is seen in the same cycle the count would reach the threshold.
    assign stall_o = en_i & ~first_i & same_s & (stall_cnt_q >= STALL_LAST);

    // Next-state for the previous-pc capture and the saturating repeat count.
    always_comb begin
        prev_pc_d   = prev_pc_q;
        stall_cnt_d = stall_cnt_q;
        if (clr_i) begin
            stall_cnt_d = '0;
        end else if (en_i) begin
            prev_pc_d = pc_i;
            if (first_i || !same_s) begin
                stall_cnt_d = '0;
            end else if (stall_cnt_q != STALL_MAX) begin
                stall_cnt_d = stall_cnt_q + SCW'(1);
            end else begin
                stall_cnt_d = stall_cnt_q;
            end
        end else begin
            prev_pc_d   = prev_pc_q;
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_pc_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            prev_pc_q   <= prev_pc_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: rtl/run_sequencer.sv
// Run-control FSM for the 9-bit core: start-pulse to core reset/enable window,
// halt/stall detection, cycle budget and executed-cycle count.
module run_sequencer
    import run_pkg::*;
#(
    parameter int PCW          = RUN_PCW,
    parameter int CW           = RUN_CW,
    parameter int MAX_CYCLES   = RUN_MAX_CYCLES,
    parameter int CLR_CYCLES   = RUN_CLR_CYCLES,
    parameter int STALL_CYCLES = RUN_STALL_CYCLES
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           halt_insn,
    input  logic [PCW-1:0] pc,
    output logic           core_rst,
    output logic           core_en,
    output logic           busy,
    output logic           done,
    output logic           timeout,
    output logic [CW-1:0]  cycle_count
);

    localparam int CLRW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
    localparam logic [CLRW-1:0] CLR_LAST    = CLRW'(CLR_CYCLES - 1);
    localparam logic [CW-1:0]   BUDGET_LAST = CW'(MAX_CYCLES - 1);

    run_state_t      state_q, state_d;
    logic            start_q;
    logic [CLRW-1:0] clr_cnt_q, clr_cnt_d;
    logic [CW-1:0]   cycle_count_q, cycle_count_d;
    logic            core_rst_q, core_en_q, busy_q, done_q, timeout_q;
    logic            rise_s, fall_s, in_run_s, first_s, clear_entry_s, stall_s;

    assign rise_s        = start & ~start_q;
    assign fall_s        = ~start & start_q;
    assign in_run_s      = (state_q == RUN);
    assign first_s       = in_run_s && (cycle_count_q == '0);
    assign clear_entry_s = (state_q == ARM) && fall_s;

    pc_stall_detect #(
        .PCW          (PCW),
        .STALL_CYCLES (STALL_CYCLES)
    ) u_stall (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (clear_entry_s),
        .en_i    (in_run_s),
        .first_i (first_s),
        .pc_i    (pc),
        .stall_o (stall_s)
    );

    // FSM transitions plus clear-counter and run-cycle counter next-state.
    always_comb begin
        state_d       = state_q;
        clr_cnt_d     = clr_cnt_q;
        cycle_count_d = cycle_count_q;
        case (state_q)
            IDLE: begin
                if (rise_s) state_d = ARM;
                else        state_d = IDLE;
            end
            ARM: begin
                if (fall_s) begin
                    state_d       = CLEAR;
                    clr_cnt_d     = '0;
                    cycle_count_d = '0;
                end else begin
                    state_d = ARM;
                end
            end
            CLEAR: begin
                if (clr_cnt_q == CLR_LAST) begin
                    state_d = RUN;
                end else begin
                    clr_cnt_d = clr_cnt_q + CLRW'(1);
                end
            end
            RUN: begin
                cycle_count_d = cycle_count_q + CW'(1);
                // Halt outranks the budget when both land on the same cycle.
                if (halt_insn || stall_s)              state_d = DONE;
                else if (cycle_count_q == BUDGET_LAST) state_d = FAULT;
                else                                   state_d = RUN;
            end
            DONE, FAULT: begin
                if (rise_s) state_d = ARM;
                else        state_d = state_q;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters and outputs decoded from the next state so each output is a flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            start_q       <= 1'b0;
            clr_cnt_q     <= '0;
            cycle_count_q <= '0;
            core_rst_q    <= 1'b1;
            core_en_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            start_q       <= start;
            clr_cnt_q     <= clr_cnt_d;
            cycle_count_q <= cycle_count_d;
            core_rst_q    <= holds_core_rst(state_d);
            core_en_q     <= (state_d == RUN);
            busy_q        <= is_busy(state_d);
            done_q        <= is_finished(state_d);
            timeout_q     <= (state_d == FAULT);
        end
    end

    assign core_rst    = core_rst_q;
    assign core_en     = core_en_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout     = timeout_q;
    assign cycle_count = cycle_count_q;

endmodule
